// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers:
// passes legal lamp codes through one cycle late, latches a flashing-red fault on unsafe sequences.
module traffic_conflict_monitor #(
    parameter int unsigned FILTER     = 4,
    parameter int unsigned FLASH_HALF = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] main_road,
    input  logic [2:0] side_road,
    input  logic       clear_fault,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned VW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_INVALID  = 2'b10;
    localparam logic [1:0] CODE_SKIP     = 2'b11;

    typedef enum logic [1:0] {
        MONITOR,
        FAULT_ON,
        FAULT_OFF
    } state_t;

    state_t        state;
    logic [VW-1:0] viol_cnt;
    logic [FW-1:0] flash_cnt;
    logic [2:0]    prev_main;
    logic [2:0]    prev_side;

    logic main_ok, side_ok, conflict, invalid, violation, skip;

    always_comb begin
        main_ok   = main_road inside {RED, YEL, GRN};
        side_ok   = side_road inside {RED, YEL, GRN};
        conflict  = (main_road != RED) && (side_road != RED);
        invalid   = !main_ok || !side_ok;
        violation = conflict || invalid;
        skip      = ((prev_main == GRN) && (main_road == RED)) ||
                    ((prev_side == GRN) && (side_road == RED));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= MONITOR;
            main_lamp  <= RED;
            side_lamp  <= RED;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            viol_cnt   <= '0;
            flash_cnt  <= '0;
            prev_main  <= RED;
            prev_side  <= RED;
        end else begin
            case (state)
                MONITOR: begin
                    prev_main <= main_road;
                    prev_side <= side_road;
                    if (skip) begin
                        state      <= FAULT_ON;
                        fault      <= 1'b1;
                        fault_code <= CODE_SKIP;
                        main_lamp  <= RED;
                        side_lamp  <= RED;
                        viol_cnt   <= '0;
                        flash_cnt  <= '0;
                    end else if (violation) begin
                        main_lamp <= RED;
                        side_lamp <= RED;
                        // Counter holds the violations already seen, so the FILTER-th trips here.
                        if (viol_cnt == VW'(FILTER - 1)) begin
                            state      <= FAULT_ON;
                            fault      <= 1'b1;
                            fault_code <= conflict ? CODE_CONFLICT : CODE_INVALID;
                            viol_cnt   <= '0;
                            flash_cnt  <= '0;
                        end else begin
                            viol_cnt <= viol_cnt + VW'(1);
                        end
                    end else begin
                        main_lamp <= main_road;
                        side_lamp <= side_road;
                        viol_cnt  <= '0;
                    end
                end
                FAULT_ON, FAULT_OFF: begin
                    if (clear_fault && !violation && !skip) begin
                        state      <= MONITOR;
                        main_lamp  <= main_road;
                        side_lamp  <= side_road;
                        fault      <= 1'b0;
                        fault_code <= CODE_NONE;
                        viol_cnt   <= '0;
                        flash_cnt  <= '0;
                        prev_main  <= main_road;
                        prev_side  <= side_road;
                    end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                        flash_cnt <= '0;
                        if (state == FAULT_ON) begin
                            state     <= FAULT_OFF;
                            main_lamp <= DARK;
                            side_lamp <= DARK;
                        end else begin
                            state     <= FAULT_ON;
                            main_lamp <= RED;
                            side_lamp <= RED;
                        end
                    end else begin
                        flash_cnt <= flash_cnt + FW'(1);
                    end
                end
                default: state <= MONITOR;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: table of single-cycle vectors plus
// hand-written flash, clear and reset sequences (FILTER=4, FLASH_HALF=8).
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] main_road;
    logic [2:0] side_road;
    logic       clear_fault;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       fault;
    logic [1:0] fault_code;

    int total = 0;
    int bad   = 0;

    traffic_conflict_monitor #(
        .FILTER    (4),
        .FLASH_HALF(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .main_road  (main_road),
        .side_road  (side_road),
        .clear_fault(clear_fault),
        .main_lamp  (main_lamp),
        .side_lamp  (side_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [2:0] m;
        logic [2:0] s;
        logic       c;
        logic [2:0] em;
        logic [2:0] es;
        logic       ef;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[17];

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [2:0] m, input logic [2:0] s, input logic c);
        rst         = r;
        main_road   = m;
        side_road   = s;
        clear_fault = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] em, input logic [2:0] es,
                       input logic ef, input logic [1:0] ec);
        total++;
        if ({main_lamp, side_lamp, fault, fault_code} !== {em, es, ef, ec}) begin
            bad++;
            $display("FAIL %s: got lamps=%b/%b fault=%b code=%b, want lamps=%b/%b fault=%b code=%b",
                     name, main_lamp, side_lamp, fault, fault_code, em, es, ef, ec);
        end
    endtask

    initial begin
        rst = 1'b0; main_road = 3'b100; side_road = 3'b100; clear_fault = 1'b0;

        //           rst  main    side    clr   exp_main exp_side f  code
        vecs[0]  = '{1'b0, 3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 3'b010, 3'b100, 1'b1, 3'b010, 3'b100, 1'b0, 2'b00};
        vecs[3]  = '{1'b1, 3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00};
        vecs[4]  = '{1'b1, 3'b100, 3'b010, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00};
        vecs[5]  = '{1'b1, 3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[7]  = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[8]  = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[9]  = '{1'b1, 3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00};
        vecs[10] = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[11] = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[12] = '{1'b1, 3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};
        vecs[13] = '{1'b1, 3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00};
        vecs[14] = '{1'b1, 3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00};
        vecs[15] = '{1'b1, 3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11};
        vecs[16] = '{1'b0, 3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].m, vecs[i].s, vecs[i].c);
            chk($sformatf("vec%0d", i), vecs[i].em, vecs[i].es, vecs[i].ef, vecs[i].ec);
        end

        // Conflict held: trips on the 4th edge, then flashes 8 on / 8 off.
        step(1'b0, 3'b100, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b001, 3'b001, 1'b0);
            chk($sformatf("conflict_pre%0d", i), 3'b100, 3'b100, 1'b0, 2'b00);
        end
        for (int i = 0; i < 24; i++) begin
            logic [2:0] lamp;
            if (i > 0) begin
                step(1'b1, 3'b001, 3'b001, 1'b0);
            end else begin
                step(1'b1, 3'b001, 3'b001, 1'b0);
            end
            lamp = (((i / 8) % 2) == 0) ? 3'b100 : 3'b000;
            chk($sformatf("flash%0d", i), lamp, lamp, 1'b1, 2'b01);
        end

        // Invalid code trip, clear ignored while invalid, accepted once legal.
        step(1'b0, 3'b100, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b011, 3'b100, 1'b0);
            chk($sformatf("invalid_pre%0d", i), 3'b100, 3'b100, 1'b0, 2'b00);
        end
        step(1'b1, 3'b011, 3'b100, 1'b0);
        chk("invalid_trip", 3'b100, 3'b100, 1'b1, 2'b10);
        step(1'b1, 3'b011, 3'b100, 1'b1);
        chk("clear_ignored", 3'b100, 3'b100, 1'b1, 2'b10);
        step(1'b1, 3'b011, 3'b100, 1'b0);
        chk("still_fault", 3'b100, 3'b100, 1'b1, 2'b10);
        step(1'b1, 3'b100, 3'b001, 1'b1);
        chk("clear_ok", 3'b100, 3'b001, 1'b0, 2'b00);
        step(1'b1, 3'b100, 3'b010, 1'b0);
        chk("after_clear", 3'b100, 3'b010, 1'b0, 2'b00);

        // Reset during FAULT_OFF, then no skipped-yellow trip on the first sample.
        step(1'b0, 3'b100, 3'b100, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 3'b001, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'b001, 3'b001, 1'b0);
        chk("in_fault_off", 3'b000, 3'b000, 1'b1, 2'b01);
        step(1'b0, 3'b001, 3'b001, 1'b0);
        chk("reset_mid_flash", 3'b100, 3'b100, 1'b0, 2'b00);
        step(1'b1, 3'b001, 3'b100, 1'b0);
        chk("post_reset_pass", 3'b001, 3'b100, 1'b0, 2'b00);
        step(1'b1, 3'b010, 3'b100, 1'b0);
        chk("post_reset_pass2", 3'b010, 3'b100, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
